// File: rtl/des_subkey_sched_pkg.sv
// des_subkey_sched_pkg
//   Shared constants for the iterative DES key schedule: widths, the FIPS 46-3
//   PC-1 / PC-2 / shift tables (1-based entries), the FSM state type and the
//   28-bit half rotator used by the schedule.
//   Bit numbering: vector index i holds DES bit i+1 throughout.
package des_subkey_sched_pkg;

  localparam int DES_KEY_W    = 64;
  localparam int DES_HALF_W   = 28;
  localparam int DES_SUBKEY_W = 48;
  localparam int DES_ROUNDS   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  // PC-1: output bit j+1 takes key bit PC1[j]
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: subkey bit j+1 takes CD bit PC2[j]
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // LS[k] of round k+1
  localparam logic [1:0] LS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Left moves bits toward DES bit 1: new[i] = old[(i+amt) % 28].
  // Right is the inverse: new[i] = old[(i-amt) % 28].
  function automatic logic [DES_HALF_W-1:0] rot28(
    input logic [DES_HALF_W-1:0] v,
    input logic [1:0]            amt,
    input rot_dir_e              dir
  );
    logic [DES_HALF_W-1:0] r;
    r = '0;
    for (int i = 0; i < DES_HALF_W; i++) begin
      if (dir == ROT_LEFT) r[i] = v[(i + int'(amt)) % DES_HALF_W];
      else                 r[i] = v[(i + DES_HALF_W - int'(amt)) % DES_HALF_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_subkey_sched_if.sv
// des_subkey_sched_if
//   Key-load and subkey-stream handshakes of the DES key schedule.
//   master : key source / round engine side (drives key, accepts subkeys)
//   slave  : the key schedule itself
//   key_in/key_decrypt/key_valid/key_ready  - key load channel
//   subkey_out/round/last/valid/ready       - subkey stream channel
interface des_subkey_sched_if;
  import des_subkey_sched_pkg::*;

  logic [DES_KEY_W-1:0]    key_in;
  logic                    key_decrypt;
  logic                    key_valid;
  logic                    key_ready;
  logic [DES_SUBKEY_W-1:0] subkey_out;
  logic [3:0]              subkey_round;
  logic                    subkey_last;
  logic                    subkey_valid;
  logic                    subkey_ready;

  modport master (
    output key_in, key_decrypt, key_valid, subkey_ready,
    input  key_ready, subkey_out, subkey_round, subkey_last, subkey_valid
  );

  modport slave (
    input  key_in, key_decrypt, key_valid, subkey_ready,
    output key_ready, subkey_out, subkey_round, subkey_last, subkey_valid
  );

endinterface

// File: rtl/des_subkey_sched_pc2.sv
// des_subkey_sched_pc2
//   Combinational DES PC-2 selection, 56 -> 48 bits.
//   cd_i     : CD vector, index j = CD bit j+1 (C in [27:0], D in [55:28])
//   subkey_o : round subkey, index j = subkey bit j+1
module des_subkey_sched_pc2
  import des_subkey_sched_pkg::*;
(
  input  logic [2*DES_HALF_W-1:0] cd_i,
  output logic [DES_SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < DES_SUBKEY_W; j++) subkey_o[j] = cd_i[PC2[j]-1];
  end

endmodule

// File: rtl/des_subkey_sched.sv
// des_subkey_sched
//   Iterative DES key schedule: loads a key, then streams 16 round subkeys,
//   one per accepted handshake. Encrypt order K1..K16 (left rotations),
//   decrypt order K16..K1 (right rotations). Mode is latched with the key.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : des_subkey_sched_if.slave (key load + subkey stream)
//
//   state | meaning
//   IDLE  | waiting for a key, key_ready high (except while rst)
//   RUN   | presenting PC2(C,D) for position pos_q, waiting for subkey_ready
module des_subkey_sched
  import des_subkey_sched_pkg::*;
(
  input logic clk,
  input logic rst,
  des_subkey_sched_if.slave bus
);

  state_e                state_q, state_d;
  logic [DES_HALF_W-1:0] c_q, c_d, d_q, d_d;
  logic [3:0]            pos_q, pos_d;
  logic                  mode_q, mode_d;

  logic                    key_ready, subkey_valid, subkey_last;
  logic [3:0]              subkey_round;
  logic                    key_hs, sub_hs;
  logic [2*DES_HALF_W-1:0] pc1_out;
  logic [DES_SUBKEY_W-1:0] subkey;
  logic [3:0]              ls_idx;
  logic [1:0]              ls_amt;

  assign key_hs = bus.key_valid & key_ready;
  assign sub_hs = subkey_valid & bus.subkey_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_hs) state_d = RUN;
      RUN:  if (sub_hs && pos_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; round/last read zero outside RUN
  always_comb begin
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    subkey_round = 4'd0;
    subkey_last  = 1'b0;
    case (state_q)
      IDLE: key_ready = ~rst;
      RUN: begin
        subkey_valid = 1'b1;
        subkey_round = mode_q ? (4'd15 - pos_q) : pos_q;
        subkey_last  = (pos_q == 4'd15);
      end
      default: ;
    endcase
  end

  // PC-1: C gets bits 1..28 of the permuted key, D gets 29..56
  always_comb begin
    pc1_out = '0;
    for (int j = 0; j < 2*DES_HALF_W; j++) pc1_out[j] = bus.key_in[PC1[j]-1];
  end

  // Step shift: going from position p to p+1, encrypt needs LS of round p+2,
  // decrypt undoes the shift of round 16-p.
  assign ls_idx = mode_q ? (4'd15 - pos_q) : (pos_q + 4'd1);
  assign ls_amt = LS[ls_idx];

  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    pos_d  = pos_q;
    mode_d = mode_q;
    if (key_hs) begin
      mode_d = bus.key_decrypt;
      pos_d  = 4'd0;
      if (bus.key_decrypt) begin
        // C16/D16 equal C0/D0 (total shift 28), so K16 needs no rotation
        c_d = pc1_out[DES_HALF_W-1:0];
        d_d = pc1_out[2*DES_HALF_W-1:DES_HALF_W];
      end else begin
        c_d = rot28(pc1_out[DES_HALF_W-1:0], LS[0], ROT_LEFT);
        d_d = rot28(pc1_out[2*DES_HALF_W-1:DES_HALF_W], LS[0], ROT_LEFT);
      end
    end else if (sub_hs && pos_q != 4'd15) begin
      pos_d = pos_q + 4'd1;
      c_d   = rot28(c_q, ls_amt, mode_q ? ROT_RIGHT : ROT_LEFT);
      d_d   = rot28(d_q, ls_amt, mode_q ? ROT_RIGHT : ROT_LEFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= '0;
      d_q    <= '0;
      pos_q  <= 4'd0;
      mode_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      pos_q  <= pos_d;
      mode_q <= mode_d;
    end
  end

  des_subkey_sched_pc2 u_pc2 (
    .cd_i     ({d_q, c_q}),
    .subkey_o (subkey)
  );

  assign bus.key_ready    = key_ready;
  assign bus.subkey_valid = subkey_valid;
  assign bus.subkey_out   = subkey;
  assign bus.subkey_round = subkey_round;
  assign bus.subkey_last  = subkey_last;

endmodule

// File: tb/tb_des_subkey_sched.sv
// tb_des_subkey_sched
//   Drives keys (fixed vectors and $urandom), random subkey backpressure and a
//   mid-sequence reset. The reference builds the 16 subkeys per key in
//   standard DES order (bit 1 = MSB) by cumulative left shifts and reverses
//   the list for decrypt; results are bit-reversed onto DUT vector indices.
module tb_des_subkey_sched;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int LS_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] ks [1:16];

  des_subkey_sched_if bus ();

  des_subkey_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  // Reference: standard-order subkeys K1..K16 into ks[1..16]
  task automatic build_model(input logic [63:0] key_std);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    cd = '0;
    for (int j = 0; j < 56; j++) cd = {cd[54:0], key_std[64-PC1_T[j]]};
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < LS_T[r-1]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      k  = '0;
      for (int j = 0; j < 48; j++) k = {k[46:0], cd[56-PC2_T[j]]};
      ks[r] = k;
    end
  endtask

  // One key load plus its subkey stream. Called and returning at a negedge.
  // abort_at < 16 pulses rst while position abort_at is presented.
  // hold keeps key_valid high during RUN with the next key on the bus.
  task automatic run_seq(input logic [63:0] key_std, input bit dec, input int max_stall,
                         input int abort_at, input bit hold, input logic [63:0] nkey_std,
                         input bit ndec, output logic [47:0] first_std,
                         output logic [47:0] last_std);
    int waited;
    int stalls;
    int kidx;
    logic [47:0] exp;
    first_std = '0;
    last_std  = '0;
    build_model(key_std);
    waited = 0;
    while (bus.key_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.key_ready !== 1'b1) begin
      check("key_ready_wait", 64'(bus.key_ready), 64'd1);
      return;
    end
    bus.key_in       = rev64(key_std);
    bus.key_decrypt  = dec;
    bus.key_valid    = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    if (hold) begin
      bus.key_in      = rev64(nkey_std);
      bus.key_decrypt = ndec;
    end else begin
      bus.key_valid = 1'b0;
    end
    for (int idx = 0; idx < 16; idx++) begin
      kidx   = dec ? 16 - idx : idx + 1;
      exp    = rev48(ks[kidx]);
      stalls = (max_stall > 0) ? int'($urandom_range(32'(max_stall), 0)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        check("sub_valid", 64'(bus.subkey_valid), 64'd1);
        check("sub_out", 64'(bus.subkey_out), 64'(exp));
        check("sub_round", 64'(bus.subkey_round), 64'(dec ? 15 - idx : idx));
        check("sub_last", 64'(bus.subkey_last), 64'(idx == 15));
        check("run_key_ready", 64'(bus.key_ready), 64'd0);
        if (idx == abort_at && s == stalls) begin
          bus.subkey_ready = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          #1;
          check("abort_valid", 64'(bus.subkey_valid), 64'd0);
          check("abort_key_ready", 64'(bus.key_ready), 64'd1);
          check("abort_round", 64'(bus.subkey_round), 64'd0);
          check("abort_last", 64'(bus.subkey_last), 64'd0);
          bus.subkey_ready = 1'b1;
          for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("abort_no_sub", 64'(bus.subkey_valid), 64'd0);
          end
          bus.subkey_ready = 1'b0;
          return;
        end
        bus.subkey_ready = (s == stalls);
        if (s == stalls && idx == 0)  first_std = rev48(bus.subkey_out);
        if (s == stalls && idx == 15) last_std  = rev48(bus.subkey_out);
        @(negedge clk);
      end
    end
    bus.subkey_ready = 1'b0;
    check("done_valid", 64'(bus.subkey_valid), 64'd0);
    check("done_key_ready", 64'(bus.key_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f, l;
    logic [63:0] rk, rk2;
    rst              = 1'b1;
    bus.key_in       = '0;
    bus.key_decrypt  = 1'b0;
    bus.key_valid    = 1'b0;
    bus.subkey_ready = 1'b0;

    @(negedge clk);
    check("rst_key_ready", 64'(bus.key_ready), 64'd0);
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_key_ready", 64'(bus.key_ready), 64'd1);
    check("post_rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("post_rst_round", 64'(bus.subkey_round), 64'd0);
    check("post_rst_last", 64'(bus.subkey_last), 64'd0);
    check("post_rst_out", 64'(bus.subkey_out), 64'd0);

    // fixed vector, decrypt then encrypt, no stalls
    run_seq(KEY_STD, 1'b1, 0, 16, 1'b0, '0, 1'b0, f, l);
    check("t1_first_K16", 64'(f), 64'(K16_STD));
    check("t1_last_K1", 64'(l), 64'(K1_STD));
    run_seq(KEY_STD, 1'b0, 0, 16, 1'b0, '0, 1'b0, f, l);
    check("t2_first_K1", 64'(f), 64'(K1_STD));
    check("t2_last_K16", 64'(l), 64'(K16_STD));

    // random backpressure, fixed then random keys
    run_seq(KEY_STD, 1'b1, 5, 16, 1'b0, '0, 1'b0, f, l);
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom(), $urandom()};
      run_seq(rk, 1'(($urandom() & 32'd1) != 0), 5, 16, 1'b0, '0, 1'b0, f, l);
    end

    // reset at pos 7, then all-zero key
    rk = {$urandom(), $urandom()};
    run_seq(rk, 1'b1, 2, 7, 1'b0, '0, 1'b0, f, l);
    run_seq(64'h0, 1'b1, 0, 16, 1'b0, '0, 1'b0, f, l);
    check("t4_zero_first", 64'(f), 64'd0);
    check("t4_zero_last", 64'(l), 64'd0);

    // key_valid held during RUN, then back-to-back encrypt/decrypt
    rk2 = {$urandom(), $urandom()};
    run_seq(KEY_STD, 1'b0, 0, 16, 1'b1, rk2, 1'b1, f, l);
    run_seq(rk2, 1'b1, 0, 16, 1'b0, '0, 1'b0, f, l);
    run_seq(KEY_STD, 1'b0, 1, 16, 1'b1, KEY_STD, 1'b1, f, l);
    check("t5_enc_first", 64'(f), 64'(K1_STD));
    run_seq(KEY_STD, 1'b1, 1, 16, 1'b0, '0, 1'b0, f, l);
    check("t5_dec_first", 64'(f), 64'(K16_STD));

    // parity bits are ignored
    run_seq(KEY_STD ^ 64'h0101010101010101, 1'b1, 0, 16, 1'b0, '0, 1'b0, f, l);
    check("t6_first_K16", 64'(f), 64'(K16_STD));
    check("t6_last_K1", 64'(l), 64'(K1_STD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
